// File: rtl/ptc_deadtime_gen_pkg.sv
// Shared PTC definitions for the dead-time generator: state encodings and
// default widths.
package ptc_deadtime_gen_pkg;

  localparam int unsigned PTC_DTW = 8;
  localparam int unsigned PTC_SCW = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DEAD_H = 3'd1,
    ST_HI     = 3'd2,
    ST_DEAD_L = 3'd3,
    ST_LO     = 3'd4
  } ptc_dt_state_e;

endpackage

// File: rtl/ptc_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over
// increment.
module ptc_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {W{1'b0}};
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ptc_deadtime_gen.sv
// Complementary high/low drive generator with break-before-make dead time,
// short-pulse suppression and per-output polarity.
module ptc_deadtime_gen
  import ptc_deadtime_gen_pkg::*;
#(
  parameter int unsigned DTW = PTC_DTW,
  parameter int unsigned SCW = PTC_SCW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pwm_in,
  input  logic           oen_in,
  input  logic           cfg_en,
  input  logic [DTW-1:0] cfg_dead,
  input  logic           cfg_inv_hi,
  input  logic           cfg_inv_lo,
  input  logic           sup_clr,
  output logic           out_hi,
  output logic           out_lo,
  output logic           dead,
  output logic [SCW-1:0] sup_cnt
);

  ptc_dt_state_e  state_q, state_d;
  logic [DTW-1:0] cnt_q, cnt_d;
  logic           from_act_q, from_act_d;
  logic           hi_on_q, lo_on_q, dead_q;
  logic           run;
  logic           sup_inc;

  assign run = cfg_en & ~oen_in;

  // from_act remembers whether the current dead interval left an active side,
  // which decides where a short pulse returns to.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    from_act_d = from_act_q;
    sup_inc    = 1'b0;
    if (!run) begin
      state_d    = ST_IDLE;
      cnt_d      = {DTW{1'b0}};
      from_act_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          from_act_d = 1'b0;
          cnt_d      = cfg_dead;
          state_d    = pwm_in ? ST_DEAD_H : ST_DEAD_L;
        end
        ST_DEAD_H: begin
          if (!pwm_in) begin
            if (from_act_q) begin
              state_d = ST_LO;
              sup_inc = 1'b1;
            end else begin
              state_d = ST_DEAD_L;
              cnt_d   = cfg_dead;
            end
          end else if (cnt_q != {DTW{1'b0}}) begin
            cnt_d = cnt_q - DTW'(1);
          end else begin
            state_d = ST_HI;
          end
        end
        ST_HI: begin
          if (!pwm_in) begin
            state_d    = ST_DEAD_L;
            cnt_d      = cfg_dead;
            from_act_d = 1'b1;
          end else begin
            state_d = ST_HI;
          end
        end
        ST_DEAD_L: begin
          if (pwm_in) begin
            if (from_act_q) begin
              state_d = ST_HI;
              sup_inc = 1'b1;
            end else begin
              state_d = ST_DEAD_H;
              cnt_d   = cfg_dead;
            end
          end else if (cnt_q != {DTW{1'b0}}) begin
            cnt_d = cnt_q - DTW'(1);
          end else begin
            state_d = ST_LO;
          end
        end
        ST_LO: begin
          if (pwm_in) begin
            state_d    = ST_DEAD_H;
            cnt_d      = cfg_dead;
            from_act_d = 1'b1;
          end else begin
            state_d = ST_LO;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          cnt_d      = {DTW{1'b0}};
          from_act_d = 1'b0;
        end
      endcase
    end
  end

  // Drive flops are decoded from the next state so both sides switch on the
  // same edge as the state register and can never overlap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {DTW{1'b0}};
      from_act_q <= 1'b0;
      hi_on_q    <= 1'b0;
      lo_on_q    <= 1'b0;
      dead_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      from_act_q <= from_act_d;
      hi_on_q    <= (state_d == ST_HI);
      lo_on_q    <= (state_d == ST_LO);
      dead_q     <= (state_d == ST_DEAD_H) || (state_d == ST_DEAD_L);
    end
  end

  ptc_sat_counter #(
    .W (SCW)
  ) u_sup_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (sup_inc),
    .clr   (sup_clr),
    .count (sup_cnt)
  );

  assign out_hi = hi_on_q ^ cfg_inv_hi;
  assign out_lo = lo_on_q ^ cfg_inv_lo;
  assign dead   = dead_q;

endmodule
